// File: rtl/sram_arbiter.sv
// sram_arbiter: single-port sequencer for the external 512K x 8 async SRAM.
// Three requesters share the device: video fetch, Z80 cpu and the dma/loader.
// Priority is video > cpu > dma. A starvation counter lets dma win a cpu-vs-dma
// decision after DMA_STARVE_LIMIT consecutive cpu grants taken while dma waits.
// Every access is a fixed slot: IDLE (1 clk) + ACCESS (ACCESS_CYCLES) + RECOVER (1).
// Optional build macro: SRAMARB_ROM_WP_EN. When it is defined, a cpu write made
// while wp_on is high to an address below WP_LIMIT runs a normal slot with a
// normal ack, but the SRAM is never strobed, so the write is dropped.
// All SRAM pin controls and all acks/rdata are registered outputs.
module sram_arbiter #(
  parameter int          ACCESS_CYCLES    = 3,
  parameter int          DMA_STARVE_LIMIT = 4,
  parameter logic [18:0] WP_LIMIT         = 19'h08000
) (
  input  logic        clk,
  input  logic        rst_n,
  // video fetch (read only)
  input  logic        vid_req,
  input  logic [18:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_rdata,
  // cpu
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  // dma / loader
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [18:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  // write protect enable (only meaningful with SRAMARB_ROM_WP_EN)
  input  logic        wp_on,
  // SRAM pins
  output logic [18:0] sram_addr,
  output logic [7:0]  sram_dout,
  output logic        sram_doe,
  input  logic [7:0]  sram_din,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_VID  = 2'd1,
    SRC_CPU  = 2'd2,
    SRC_DMA  = 2'd3
  } src_t;

  // Slot counter spans 0 .. ACCESS_CYCLES-1.
  localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST       = CW'(ACCESS_CYCLES - 1);
  localparam logic [CW-1:0] CNT_STROBE_END = CW'(ACCESS_CYCLES - 2);
  localparam logic [CW-1:0] CNT_ONE        = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO       = CW'(1'b0);

  // Starvation counter saturates at DMA_STARVE_LIMIT.
  localparam int SW = (DMA_STARVE_LIMIT > 0) ? $clog2(DMA_STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX  = SW'(DMA_STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE  = SW'(1'b1);
  localparam logic [SW-1:0] STARVE_ZERO = SW'(1'b0);

  state_t         state_r;
  state_t         state_nx_s;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_nx_s;
  logic [CW-1:0]  cnt_inc_s;
  logic [SW-1:0]  starve_r;
  logic [SW-1:0]  starve_nx_s;

  // Latched slot context.
  src_t           src_r;
  logic           we_r;     // requested direction (controls rdata capture)
  logic           drive_r;  // write that really reaches the SRAM

  // Arbitration result for the current IDLE cycle.
  src_t           win_s;
  logic [18:0]    win_addr_s;
  logic           win_we_s;
  logic [7:0]     win_wdata_s;
  logic           win_block_s;
  logic           win_drive_s;
  logic           strobe_nx_s;

  // Pick the winner from the live request levels; video always wins, dma wins
  // the cpu-vs-dma decision only once the starvation counter has saturated.
  always_comb begin
    win_s = SRC_NONE;
    if (vid_req) begin
      win_s = SRC_VID;
    end else if (cpu_req && dma_req && (starve_r == STARVE_MAX)) begin
      win_s = SRC_DMA;
    end else if (cpu_req) begin
      win_s = SRC_CPU;
    end else if (dma_req) begin
      win_s = SRC_DMA;
    end else begin
      win_s = SRC_NONE;
    end
  end

  // Route the winner's address, direction and write data to the latch inputs.
  always_comb begin
    win_addr_s  = 19'h00000;
    win_we_s    = 1'b0;
    win_wdata_s = 8'h00;
    case (win_s)
      SRC_VID: begin
        win_addr_s  = vid_addr;
        win_we_s    = 1'b0;
        win_wdata_s = 8'h00;
      end
      SRC_CPU: begin
        win_addr_s  = cpu_addr;
        win_we_s    = cpu_we;
        win_wdata_s = cpu_wdata;
      end
      SRC_DMA: begin
        win_addr_s  = dma_addr;
        win_we_s    = dma_we;
        win_wdata_s = dma_wdata;
      end
      default: begin
        win_addr_s  = 19'h00000;
        win_we_s    = 1'b0;
        win_wdata_s = 8'h00;
      end
    endcase
  end

`ifdef SRAMARB_ROM_WP_EN
  // Only cpu writes into the protected low region are suppressed.
  assign win_block_s = (win_s == SRC_CPU) && cpu_we && wp_on && (cpu_addr < WP_LIMIT);
`else
  // Protection not built: wp_on and WP_LIMIT have no effect.
  logic unused_wp;
  assign unused_wp   = wp_on | (WP_LIMIT == 19'h00000);
  assign win_block_s = 1'b0;
`endif

  assign win_drive_s = win_we_s & ~win_block_s;
  assign cnt_inc_s   = cnt_r + CNT_ONE;
  // Write strobe is low for counts 1 .. ACCESS_CYCLES-2 of a driving slot.
  assign strobe_nx_s = (cnt_inc_s <= CNT_STROBE_END);

  // FSM next-state and slot counter.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (win_s != SRC_NONE) begin
          state_nx_s = ACCESS;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          state_nx_s = IDLE;
          cnt_nx_s   = cnt_r;
        end
      end
      ACCESS: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = RECOVER;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          state_nx_s = ACCESS;
          cnt_nx_s   = cnt_inc_s;
        end
      end
      RECOVER: begin
        state_nx_s = IDLE;
        cnt_nx_s   = CNT_ZERO;
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
  end

  // Starvation counter: counts cpu grants taken over a waiting dma, only in IDLE.
  always_comb begin
    starve_nx_s = starve_r;
    if (state_r == IDLE) begin
      if (win_s == SRC_DMA) begin
        starve_nx_s = STARVE_ZERO;
      end else if (!dma_req) begin
        starve_nx_s = STARVE_ZERO;
      end else if ((win_s == SRC_CPU) && (starve_r != STARVE_MAX)) begin
        starve_nx_s = starve_r + STARVE_ONE;
      end else begin
        starve_nx_s = starve_r;
      end
    end else begin
      starve_nx_s = starve_r;
    end
  end

  // FSM state, slot counter and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      starve_r <= STARVE_ZERO;
    end else begin
      state_r  <= state_nx_s;
      cnt_r    <= cnt_nx_s;
      starve_r <= starve_nx_s;
    end
  end

  // Slot datapath: latch context, drive SRAM pins, capture read data, pulse ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_r     <= SRC_NONE;
      we_r      <= 1'b0;
      drive_r   <= 1'b0;
      sram_addr <= 19'h00000;
      sram_dout <= 8'h00;
      sram_doe  <= 1'b0;
      sram_we_n <= 1'b1;
      vid_ack   <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      vid_rdata <= 8'h00;
      cpu_rdata <= 8'h00;
      dma_rdata <= 8'h00;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state_r)
        IDLE: begin
          sram_doe  <= 1'b0;
          sram_we_n <= 1'b1;
          if (win_s != SRC_NONE) begin
            src_r     <= win_s;
            we_r      <= win_we_s;
            drive_r   <= win_drive_s;
            sram_addr <= win_addr_s;
            sram_dout <= win_wdata_s;
            sram_doe  <= win_drive_s;
          end
        end
        ACCESS: begin
          if (cnt_r == CNT_LAST) begin
            sram_doe  <= 1'b0;
            sram_we_n <= 1'b1;
            case (src_r)
              SRC_VID: begin
                vid_ack   <= 1'b1;
                vid_rdata <= sram_din;
              end
              SRC_CPU: begin
                cpu_ack <= 1'b1;
                if (!we_r) begin
                  cpu_rdata <= sram_din;
                end
              end
              SRC_DMA: begin
                dma_ack <= 1'b1;
                if (!we_r) begin
                  dma_rdata <= sram_din;
                end
              end
              default: begin
                vid_ack <= 1'b0;
              end
            endcase
          end else begin
            sram_doe  <= drive_r;
            sram_we_n <= ~(drive_r & strobe_nx_s);
          end
        end
        RECOVER: begin
          sram_doe  <= 1'b0;
          sram_we_n <= 1'b1;
        end
        default: begin
          sram_doe  <= 1'b0;
          sram_we_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed-vector bench for sram_arbiter with hand-computed
// expectations. Inputs are driven 1 time unit after the rising edge and
// outputs are sampled at that same point, away from the active edge.
module tb_sram_arbiter;

  localparam int ACCESS_CYCLES = 3;

  logic        clk;
  logic        rst_n;
  logic        vid_req;
  logic [18:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        dma_req;
  logic        dma_we;
  logic [18:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        wp_on;
  logic [18:0] sram_addr;
  logic [7:0]  sram_dout;
  logic        sram_doe;
  logic [7:0]  sram_din;
  logic        sram_we_n;

  int checks;
  int failures;

  int seq_q [8];
  int cyc_q [8];
  int n_got;
  int dbl;

  sram_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_ack   (vid_ack),
    .vid_rdata (vid_rdata),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .wp_on     (wp_on),
    .sram_addr (sram_addr),
    .sram_dout (sram_dout),
    .sram_doe  (sram_doe),
    .sram_din  (sram_din),
    .sram_we_n (sram_we_n)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cpu or dma slot; collects per-cycle observations until the ack.
  task automatic run_slot(input bit is_dma, input logic we, input logic [18:0] addr,
                          input logic [7:0] wdata,
                          output int ack_cyc, output int doe_cnt, output int wen_cnt,
                          output int wen_first, output int addr_cnt, output int dout_ok,
                          output int stray, output int ack_tail);
    ack_cyc = -1; doe_cnt = 0; wen_cnt = 0; wen_first = -1;
    addr_cnt = 0; dout_ok = 0; stray = 0; ack_tail = 0;
    @(posedge clk); #1;
    if (is_dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    for (int i = 1; i <= 12 && ack_cyc < 0; i++) begin
      @(posedge clk); #1;
      if (sram_doe) begin
        doe_cnt++;
        if (sram_dout == wdata) dout_ok++;
      end
      if (!sram_we_n) begin
        wen_cnt++;
        if (wen_first < 0) wen_first = i;
      end
      if (sram_addr == addr) addr_cnt++;
      if (vid_ack || (is_dma ? cpu_ack : dma_ack)) stray++;
      if (is_dma ? dma_ack : cpu_ack) ack_cyc = i;
    end
    // requester samples ack on this edge and drops req
    @(posedge clk); #1;
    ack_tail = is_dma ? int'(dma_ack) : int'(cpu_ack);
    if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
  endtask

  // Several read requesters at once; records ack order and cycle numbers.
  task automatic run_multi(input bit v, input bit c, input bit d, input bit cpu_hold,
                           input int n_want);
    bit drop_v, drop_c, drop_d;
    drop_v = 1'b0; drop_c = 1'b0; drop_d = 1'b0;
    n_got = 0; dbl = 0;
    @(posedge clk); #1;
    vid_req = v; vid_addr = 19'h04000;
    cpu_req = c; cpu_we = 1'b0; cpu_addr = 19'h01000;
    dma_req = d; dma_we = 1'b0; dma_addr = 19'h02000;
    for (int i = 1; i <= 60 && n_got < n_want; i++) begin
      @(posedge clk); #1;
      if (drop_v) vid_req = 1'b0;
      if (drop_c) cpu_req = 1'b0;
      if (drop_d) dma_req = 1'b0;
      drop_v = 1'b0; drop_c = 1'b0; drop_d = 1'b0;
      if ((int'(vid_ack) + int'(cpu_ack) + int'(dma_ack)) > 1) dbl++;
      if (vid_ack) begin
        seq_q[n_got] = 1; cyc_q[n_got] = i; n_got++; drop_v = 1'b1;
      end else if (cpu_ack) begin
        seq_q[n_got] = 2; cyc_q[n_got] = i; n_got++; drop_c = !cpu_hold;
      end else if (dma_ack) begin
        seq_q[n_got] = 3; cyc_q[n_got] = i; n_got++; drop_d = 1'b1;
      end
    end
    @(posedge clk); #1;
    vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    @(posedge clk); #1;
  endtask

  int ack_cyc, doe_cnt, wen_cnt, wen_first, addr_cnt, dout_ok, stray, ack_tail;
  int acks_seen, strobes_seen;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    vid_req = 1'b0; vid_addr = 19'h00000;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 19'h00000; cpu_wdata = 8'h00;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 19'h00000; dma_wdata = 8'h00;
    wp_on = 1'b0; sram_din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check_val("rst_we_n", sram_we_n, 1);
    check_val("rst_doe", sram_doe, 0);
    check_val("rst_addr", sram_addr, 0);
    check_val("rst_dout", sram_dout, 0);
    check_val("rst_acks", {vid_ack, cpu_ack, dma_ack}, 0);
    check_val("rst_rdata", {vid_rdata, cpu_rdata, dma_rdata}, 0);
    @(negedge clk); rst_n = 1'b1;

    // single cpu read
    sram_din = 8'hA5;
    run_slot(1'b0, 1'b0, 19'h12345, 8'h00, ack_cyc, doe_cnt, wen_cnt, wen_first,
             addr_cnt, dout_ok, stray, ack_tail);
    check_val("rd_ack_lat", ack_cyc, 4);
    check_val("rd_addr_cyc", addr_cnt, 4);
    check_val("rd_doe", doe_cnt, 0);
    check_val("rd_we_n", wen_cnt, 0);
    check_val("rd_ack_len", ack_tail, 0);
    sram_din = 8'h00;
    check_val("rd_rdata", cpu_rdata, 8'hA5);

    // cpu write 3C to top of memory
    run_slot(1'b0, 1'b1, 19'h7FFFF, 8'h3C, ack_cyc, doe_cnt, wen_cnt, wen_first,
             addr_cnt, dout_ok, stray, ack_tail);
    check_val("wr_ack_lat", ack_cyc, 4);
    check_val("wr_doe", doe_cnt, 3);
    check_val("wr_dout", dout_ok, 3);
    check_val("wr_strobe_cnt", wen_cnt, 1);
    check_val("wr_strobe_at", wen_first, 2);
    check_val("wr_addr_cyc", addr_cnt, 4);
    check_val("wr_ack_len", ack_tail, 0);
    check_val("wr_rdata_hold", cpu_rdata, 8'hA5);

    // dma read
    sram_din = 8'h5A;
    run_slot(1'b1, 1'b0, 19'h00042, 8'h00, ack_cyc, doe_cnt, wen_cnt, wen_first,
             addr_cnt, dout_ok, stray, ack_tail);
    check_val("dma_ack_lat", ack_cyc, 4);
    check_val("dma_stray", stray, 0);
    check_val("dma_rdata", dma_rdata, 8'h5A);
    check_val("dma_cpu_hold", cpu_rdata, 8'hA5);

    // video read
    sram_din = 8'hC3;
    run_multi(1'b1, 1'b0, 1'b0, 1'b0, 1);
    check_val("vid_cnt", n_got, 1);
    check_val("vid_lat", cyc_q[0], 4);
    check_val("vid_rdata", vid_rdata, 8'hC3);
    check_val("vid_cpu_hold", cpu_rdata, 8'hA5);

    // all three at once: vid, cpu, dma, 5 clocks apart
    run_multi(1'b1, 1'b1, 1'b1, 1'b0, 3);
    check_val("all3_cnt", n_got, 3);
    check_val("all3_order", {seq_q[0][3:0], seq_q[1][3:0], seq_q[2][3:0]}, 12'h123);
    check_val("all3_cyc0", cyc_q[0], 4);
    check_val("all3_cyc1", cyc_q[1], 9);
    check_val("all3_cyc2", cyc_q[2], 14);
    check_val("all3_dbl", dbl, 0);

    // starvation: cpu holds req, dma waits
    run_multi(1'b0, 1'b1, 1'b1, 1'b1, 6);
    check_val("starve_cnt", n_got, 6);
    check_val("starve_order",
              {seq_q[0][3:0], seq_q[1][3:0], seq_q[2][3:0],
               seq_q[3][3:0], seq_q[4][3:0], seq_q[5][3:0]}, 24'h222232);
    check_val("starve_cyc4", cyc_q[4], 24);
    check_val("starve_cyc5", cyc_q[5], 29);
    check_val("starve_dbl", dbl, 0);

    // write protect
    wp_on = 1'b1;
    run_slot(1'b0, 1'b1, 19'h00100, 8'h77, ack_cyc, doe_cnt, wen_cnt, wen_first,
             addr_cnt, dout_ok, stray, ack_tail);
    check_val("wp_lo_ack", ack_cyc, 4);
`ifdef SRAMARB_ROM_WP_EN
    check_val("wp_lo_strobe", wen_cnt, 0);
    check_val("wp_lo_doe", doe_cnt, 0);
`else
    check_val("wp_lo_strobe", wen_cnt, 1);
    check_val("wp_lo_doe", doe_cnt, 3);
`endif
    run_slot(1'b0, 1'b1, 19'h07FFF, 8'h78, ack_cyc, doe_cnt, wen_cnt, wen_first,
             addr_cnt, dout_ok, stray, ack_tail);
`ifdef SRAMARB_ROM_WP_EN
    check_val("wp_edge_strobe", wen_cnt, 0);
`else
    check_val("wp_edge_strobe", wen_cnt, 1);
`endif
    run_slot(1'b0, 1'b1, 19'h08000, 8'h79, ack_cyc, doe_cnt, wen_cnt, wen_first,
             addr_cnt, dout_ok, stray, ack_tail);
    check_val("wp_lim_strobe", wen_cnt, 1);
    check_val("wp_lim_at", wen_first, 2);
    run_slot(1'b1, 1'b1, 19'h00100, 8'h7A, ack_cyc, doe_cnt, wen_cnt, wen_first,
             addr_cnt, dout_ok, stray, ack_tail);
    check_val("wp_dma_strobe", wen_cnt, 1);
    check_val("wp_dma_ack", ack_cyc, 4);
    wp_on = 1'b0;

    // reset in the middle of a cpu write
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00ABC; cpu_wdata = 8'h11;
    @(posedge clk); #1;
    check_val("mid_c0_doe", sram_doe, 1);
    @(posedge clk); #1;
    check_val("mid_c1_we_n", sram_we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_we_n", sram_we_n, 1);
    check_val("mid_rst_doe", sram_doe, 0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    acks_seen = 0; strobes_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (cpu_ack) acks_seen++;
      if (!sram_we_n) strobes_seen++;
    end
    check_val("mid_no_ack", acks_seen, 0);
    check_val("mid_no_strobe", strobes_seen, 0);
    check_val("mid_rdata_rst", cpu_rdata, 8'h00);

    // a normal read after the aborted slot
    sram_din = 8'h96;
    run_slot(1'b0, 1'b0, 19'h00200, 8'h00, ack_cyc, doe_cnt, wen_cnt, wen_first,
             addr_cnt, dout_ok, stray, ack_tail);
    check_val("post_ack_lat", ack_cyc, 4);
    check_val("post_rdata", cpu_rdata, 8'h96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
